// File: rtl/iobuff_dir_sequencer.sv
// ---------------------------------------------------------------------------
// iobuff_dir_sequencer
//
// Applies per-pin configuration changes (direction, open-drain, output enable)
// to a bank of iobuff level-shifter channels.
//
// Break-before-make ordering keeps the FPGA pin and the external buffer from
// driving against each other:
//   1. Drop oe.
//   2. Wait out a guard time.
//   3. Change dir/od.
//   4. Wait out a settle time.
//   5. Restore oe.
//
// When dir/od already match the request, only oe is updated, in one edge.
//
// Parameters:
//   N_PINS   - number of iobuff channels (1..16)
//   DEADTIME - guard/settle length in clk cycles (1..255)
//   PW       - pin index width
//
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   cfg_valid/cfg_ready           - request handshake
//   cfg_pin, cfg_dir, cfg_od,
//   cfg_oe                        - request fields, latched at acceptance
//   kill                          - level: tristate every pin, abort request
//   pin_oe, pin_dir, pin_od       - per-channel controls to the iobuff bank
//   done                          - one-cycle pulse: request completed
//   err                           - one-cycle pulse: request rejected or
//                                   oe clamped
// ---------------------------------------------------------------------------
module iobuff_dir_sequencer #(
    parameter int N_PINS   = 4,
    parameter int DEADTIME = 4,
    parameter int PW       = (N_PINS > 1) ? $clog2(N_PINS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [PW-1:0]     cfg_pin,
    input  logic              cfg_dir,
    input  logic              cfg_od,
    input  logic              cfg_oe,
    input  logic              kill,
    output logic [N_PINS-1:0] pin_oe,
    output logic [N_PINS-1:0] pin_dir,
    output logic [N_PINS-1:0] pin_od,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE,
        GUARD,
        SETTLE
    } state_t;

    localparam logic [7:0] CNT_RELOAD = 8'(DEADTIME - 1);
    // One extra bit so an index equal to N_PINS can still be represented.
    localparam logic [PW:0] PIN_LIMIT = (PW + 1)'(N_PINS);

    state_t            state_q,     state_d;
    logic [7:0]        cnt_q,       cnt_d;
    logic [PW-1:0]     req_pin_q,   req_pin_d;
    logic              req_dir_q,   req_dir_d;
    logic              req_od_q,    req_od_d;
    logic              req_oe_q,    req_oe_d;
    logic              req_clamp_q, req_clamp_d;
    logic [N_PINS-1:0] pin_oe_q,    pin_oe_d;
    logic [N_PINS-1:0] pin_dir_q,   pin_dir_d;
    logic [N_PINS-1:0] pin_od_q,    pin_od_d;
    logic              done_q,      done_d;
    logic              err_q,       err_d;

    logic [N_PINS-1:0] cfg_sel;
    logic [N_PINS-1:0] req_sel;
    logic              pin_ok;
    logic              cur_dir;
    logic              cur_od;
    logic              eff_oe;
    logic              clamp;

    assign cfg_ready = (state_q == IDLE) && !kill;

    // One-hot channel selects.
    // Out-of-range indices simply select nothing, so the pin vectors are
    // never indexed past their width.
    always_comb begin
        cfg_sel = '0;
        req_sel = '0;
        for (int i = 0; i < N_PINS; i++) begin
            cfg_sel[i] = (cfg_pin == PW'(i));
            req_sel[i] = (req_pin_q == PW'(i));
        end
    end

    assign pin_ok  = ({1'b0, cfg_pin} < PIN_LIMIT);
    assign cur_dir = |(pin_dir_q & cfg_sel);
    assign cur_od  = |(pin_od_q & cfg_sel);
    // Driving the FPGA pin while the buffer points inward is illegal.
    // Such a request is clamped to oe = 0.
    assign eff_oe  = cfg_oe & cfg_dir;
    assign clamp   = cfg_oe & ~cfg_dir;

    // Next-state logic.
    // kill outranks any request; rst is handled in the register block below.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_pin_d   = req_pin_q;
        req_dir_d   = req_dir_q;
        req_od_d    = req_od_q;
        req_oe_d    = req_oe_q;
        req_clamp_d = req_clamp_q;
        pin_oe_d    = pin_oe_q;
        pin_dir_d   = pin_dir_q;
        pin_od_d    = pin_od_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        if (kill) begin
            pin_oe_d = '0;
            state_d  = IDLE;
            cnt_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_valid) begin
                        if (!pin_ok) begin
                            err_d = 1'b1;
                        end else if (cur_dir == cfg_dir && cur_od == cfg_od) begin
                            // Fast path: no direction change, so oe can move
                            // immediately.
                            pin_oe_d = (pin_oe_q & ~cfg_sel) | ({N_PINS{eff_oe}} & cfg_sel);
                            done_d   = 1'b1;
                            err_d    = clamp;
                        end else begin
                            pin_oe_d    = pin_oe_q & ~cfg_sel;
                            req_pin_d   = cfg_pin;
                            req_dir_d   = cfg_dir;
                            req_od_d    = cfg_od;
                            req_oe_d    = eff_oe;
                            req_clamp_d = clamp;
                            cnt_d       = CNT_RELOAD;
                            state_d     = GUARD;
                        end
                    end
                end
                GUARD: begin
                    if (cnt_q == 8'd0) begin
                        pin_dir_d = (pin_dir_q & ~req_sel) | ({N_PINS{req_dir_q}} & req_sel);
                        pin_od_d  = (pin_od_q & ~req_sel) | ({N_PINS{req_od_q}} & req_sel);
                        cnt_d     = CNT_RELOAD;
                        state_d   = SETTLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                SETTLE: begin
                    if (cnt_q == 8'd0) begin
                        pin_oe_d = (pin_oe_q & ~req_sel) | ({N_PINS{req_oe_q}} & req_sel);
                        done_d   = 1'b1;
                        err_d    = req_clamp_q;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // All state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_pin_q   <= '0;
            req_dir_q   <= 1'b0;
            req_od_q    <= 1'b0;
            req_oe_q    <= 1'b0;
            req_clamp_q <= 1'b0;
            pin_oe_q    <= '0;
            pin_dir_q   <= '0;
            pin_od_q    <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_pin_q   <= req_pin_d;
            req_dir_q   <= req_dir_d;
            req_od_q    <= req_od_d;
            req_oe_q    <= req_oe_d;
            req_clamp_q <= req_clamp_d;
            pin_oe_q    <= pin_oe_d;
            pin_dir_q   <= pin_dir_d;
            pin_od_q    <= pin_od_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign pin_oe  = pin_oe_q;
    assign pin_dir = pin_dir_q;
    assign pin_od  = pin_od_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_iobuff_dir_sequencer.sv
// ---------------------------------------------------------------------------
// tb_iobuff_dir_sequencer
//
// Self-checking bench for iobuff_dir_sequencer.
// The DUT is built with N_PINS=3 and DEADTIME=4, so pin index 3 is out of
// range.
//
// A timestamp-based reference model tracks:
//   - accept edge of the pending request
//   - edge numbers at which dir/od and oe are due
// The model is compared on every cycle, alongside:
//   - a hand-written vector table
//   - hand-written kill and reset sequences
// ---------------------------------------------------------------------------
module tb_iobuff_dir_sequencer;

    localparam int N  = 3;
    localparam int D  = 4;
    localparam int PW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [PW-1:0] cfg_pin = '0;
    logic          cfg_dir = 1'b0;
    logic          cfg_od = 1'b0;
    logic          cfg_oe = 1'b0;
    logic          kill = 1'b0;
    logic [N-1:0]  pin_oe;
    logic [N-1:0]  pin_dir;
    logic [N-1:0]  pin_od;
    logic          done;
    logic          err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    iobuff_dir_sequencer #(
        .N_PINS   (N),
        .DEADTIME (D),
        .PW       (PW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_pin   (cfg_pin),
        .cfg_dir   (cfg_dir),
        .cfg_od    (cfg_od),
        .cfg_oe    (cfg_oe),
        .kill      (kill),
        .pin_oe    (pin_oe),
        .pin_dir   (pin_dir),
        .pin_od    (pin_od),
        .done      (done),
        .err       (err)
    );

    // Reference model state.
    // A pending request is just its accept edge number; dir/od fall due D
    // edges later and oe falls due 2*D edges later.
    logic [N-1:0] m_oe = '0;
    logic [N-1:0] m_dir = '0;
    logic [N-1:0] m_od = '0;
    logic         m_done = 1'b0;
    logic         m_err = 1'b0;
    bit           m_pend = 1'b0;
    int           m_cyc = 0;
    int           m_tacc = 0;
    int           m_pin = 0;
    logic         m_rdir = 1'b0;
    logic         m_rod = 1'b0;
    logic         m_roe = 1'b0;
    logic         m_rclamp = 1'b0;

    task automatic modelEdge();
        int n;
        m_cyc++;
        if (rst) begin
            m_oe = '0;
            m_dir = '0;
            m_od = '0;
            m_done = 1'b0;
            m_err = 1'b0;
            m_pend = 1'b0;
        end else if (kill) begin
            m_oe = '0;
            m_done = 1'b0;
            m_err = 1'b0;
            m_pend = 1'b0;
        end else begin
            m_done = 1'b0;
            m_err = 1'b0;
            if (m_pend) begin
                n = m_cyc - m_tacc;
                if (n == D) begin
                    m_dir[m_pin] = m_rdir;
                    m_od[m_pin]  = m_rod;
                end
                if (n == 2 * D) begin
                    m_oe[m_pin] = m_roe;
                    m_done = 1'b1;
                    m_err = m_rclamp;
                    m_pend = 1'b0;
                end
            end else if (cfg_valid) begin
                if (int'(cfg_pin) >= N) begin
                    m_err = 1'b1;
                end else if (m_dir[cfg_pin] == cfg_dir && m_od[cfg_pin] == cfg_od) begin
                    m_oe[cfg_pin] = cfg_oe && cfg_dir;
                    m_done = 1'b1;
                    m_err = cfg_oe && !cfg_dir;
                end else begin
                    m_oe[cfg_pin] = 1'b0;
                    m_pend = 1'b1;
                    m_tacc = m_cyc;
                    m_pin = int'(cfg_pin);
                    m_rdir = cfg_dir;
                    m_rod = cfg_od;
                    m_roe = cfg_oe && cfg_dir;
                    m_rclamp = cfg_oe && !cfg_dir;
                end
            end
        end
    endtask

    // Compares {pin_oe, pin_dir, pin_od, done, err, cfg_ready} as one word.
    task automatic checkOutput(input string name, input logic [3*N+2:0] exp);
        logic [3*N+2:0] got;
        got = {pin_oe, pin_dir, pin_od, done, err, cfg_ready};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got oe/dir/od/done/err/rdy=%b expected %b", name, got, exp);
        end
    endtask

    // Drives one cycle of inputs, clocks once and checks against the model.
    task automatic applyStimulus(input logic r, input logic k, input logic v,
                                 input logic [PW-1:0] p, input logic d,
                                 input logic o, input logic e);
        rst = r;
        kill = k;
        cfg_valid = v;
        cfg_pin = p;
        cfg_dir = d;
        cfg_od = o;
        cfg_oe = e;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput($sformatf("model@%0d", m_cyc),
                    {m_oe, m_dir, m_od, m_done, m_err, !m_pend && !kill});
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic          rst;
        logic          kill;
        logic          valid;
        logic [PW-1:0] pin;
        logic          dir;
        logic          od;
        logic          oe;
        logic [N-1:0]  e_oe;
        logic [N-1:0]  e_dir;
        logic [N-1:0]  e_od;
        logic          e_done;
        logic          e_err;
        logic          e_ready;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(logic r, logic k, logic v, logic [PW-1:0] p,
                                   logic d, logic o, logic e,
                                   logic [N-1:0] xoe, logic [N-1:0] xdir,
                                   logic [N-1:0] xod, logic xdone,
                                   logic xerr, logic xrdy);
        vec_t t;
        t.rst = r;
        t.kill = k;
        t.valid = v;
        t.pin = p;
        t.dir = d;
        t.od = o;
        t.oe = e;
        t.e_oe = xoe;
        t.e_dir = xdir;
        t.e_od = xod;
        t.e_done = xdone;
        t.e_err = xerr;
        t.e_ready = xrdy;
        vecs.push_back(t);
    endfunction

    initial begin
        vec_t v;
        int   seen;

        // Reset, then a full-path request on pin 1: dir at E4, oe at E8.
        addVec(1, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0, 0, 1);
        addVec(1, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0, 0, 1);
        addVec(0, 0, 1, 1, 1, 0, 1, 3'b000, 3'b000, 3'b000, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            addVec(0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            addVec(0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b010, 3'b000, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 0, 3'b010, 3'b010, 3'b000, 1, 0, 1);

        // Back-to-back fast path on pin 1: oe 0 then 1.
        addVec(0, 0, 1, 1, 1, 0, 0, 3'b000, 3'b010, 3'b000, 1, 0, 1);
        addVec(0, 0, 1, 1, 1, 0, 1, 3'b010, 3'b010, 3'b000, 1, 0, 1);
        addVec(0, 0, 0, 0, 0, 0, 0, 3'b010, 3'b010, 3'b000, 0, 0, 1);

        // Clamped full-path request on pin 2 (dir=0, od=1, oe=1).
        addVec(0, 0, 1, 2, 0, 1, 1, 3'b010, 3'b010, 3'b000, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            addVec(0, 0, 0, 0, 0, 0, 0, 3'b010, 3'b010, 3'b000, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            addVec(0, 0, 0, 0, 0, 0, 0, 3'b010, 3'b010, 3'b100, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 0, 3'b010, 3'b010, 3'b100, 1, 1, 1);
        addVec(0, 0, 0, 0, 0, 0, 0, 3'b010, 3'b010, 3'b100, 0, 0, 1);

        // Clamped fast path on pin 2, then the out-of-range pin 3.
        addVec(0, 0, 1, 2, 0, 1, 1, 3'b010, 3'b010, 3'b100, 1, 1, 1);
        addVec(0, 0, 1, 3, 1, 1, 1, 3'b010, 3'b010, 3'b100, 0, 1, 1);
        addVec(0, 0, 0, 0, 0, 0, 0, 3'b010, 3'b010, 3'b100, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            applyStimulus(v.rst, v.kill, v.valid, v.pin, v.dir, v.od, v.oe);
            checkOutput($sformatf("vec[%0d]", i),
                        {v.e_oe, v.e_dir, v.e_od, v.e_done, v.e_err, v.e_ready});
        end

        // kill at E2 of a full-path request on pin 0.
        applyStimulus(0, 0, 1, 0, 1, 1, 1);
        checkOutput("kill_accept", {3'b010, 3'b010, 3'b100, 1'b0, 1'b0, 1'b0});
        idleCycle();
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("kill_e2", {3'b000, 3'b010, 3'b100, 1'b0, 1'b0, 1'b0});
        applyStimulus(0, 1, 1, 1, 1, 0, 1);
        checkOutput("kill_hold", {3'b000, 3'b010, 3'b100, 1'b0, 1'b0, 1'b0});
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            idleCycle();
            if (done) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("[TB] FAIL kill_no_done: got %0d done pulses expected 0", seen);
        end
        checkOutput("kill_after", {3'b000, 3'b010, 3'b100, 1'b0, 1'b0, 1'b1});

        // rst at E5 of a full-path request on pin 0.
        applyStimulus(0, 0, 1, 1, 1, 0, 1);
        checkOutput("rst_fast", {3'b010, 3'b010, 3'b100, 1'b1, 1'b0, 1'b1});
        applyStimulus(0, 0, 1, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) idleCycle();
        checkOutput("rst_e4", {3'b010, 3'b011, 3'b100, 1'b0, 1'b0, 1'b0});
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_e5", {3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1});
        applyStimulus(0, 0, 1, 0, 1, 0, 1);
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            idleCycle();
            if (done) seen = 1;
        end
        n_tests++;
        if (seen == 0) begin
            n_fail++;
            $display("[TB] FAIL rst_recover_done: got no done expected done within 20 cycles");
        end
        checkOutput("rst_recover", {3'b001, 3'b001, 3'b000, 1'b1, 1'b0, 1'b1});

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(63) == 0), ($urandom_range(15) == 0),
                          1'($urandom_range(1)), 2'($urandom_range(3)),
                          1'($urandom_range(1)), 1'($urandom_range(1)),
                          1'($urandom_range(1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
